btn_pulse_gen: RTL
==================

Name: btn_pulse_gen

Overview:
- Turns one raw push-button input into clean single-cycle command pulses.
- pulse_press drives the toggle input of the display/mode controllers; pulse_long and pulse_rep drive set and adjust functions.
- Flow: 2-FF synchronizer -> consistency-count debouncer -> press/hold FSM.
- One instance per physical button.

Parameters:
- DEBOUNCE_CYC, 1_000_000, consecutive cycles the synchronized input must differ from the debounced level before that level flips (10 ms at 100 MHz); must be >= 2.
- LONG_CYC, 100_000_000, cycles from pulse_press to pulse_long; must be > DEBOUNCE_CYC.
- REPEAT_CYC, 20_000_000, period of pulse_rep while held after pulse_long; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_in  in  1  raw button, asynchronous to clk, bouncing, active-high.
- en  in  1  pulse enable; low suppresses all pulses.
- level  out  1  debounced button level.
- pulse_press  out  1  one-cycle pulse on debounced press.
- pulse_long  out  1  one-cycle pulse once per press when held LONG_CYC.
- pulse_rep  out  1  one-cycle auto-repeat pulse after pulse_long.

Behaviour:
- Reset (asynchronous, immediate):
  - sync FFs = 0, level = 0, all counters = 0, FSM = IDLE.
  - All pulse outputs are 0.
- Synchronizer: btn_in passes through two FFs to give s.
- Debounce counter dcnt, width $clog2(DEBOUNCE_CYC):
  - Each edge where s != level: dcnt increments.
  - When dcnt == DEBOUNCE_CYC-1 and s != level: level <= s and dcnt <= 0.
  - Any edge where s == level: dcnt <= 0. A bounce shorter than DEBOUNCE_CYC therefore never changes level.
- Latency: if btn_in goes high before edge 0 and stays high, level rises at edge DEBOUNCE_CYC+1. pulse_press is high for exactly the cycle after edge DEBOUNCE_CYC+2. Release has the same latency.
- FSM states: IDLE, PRESSED, HELD, WAIT_REL. The counter hcnt, width $clog2(max(LONG_CYC,REPEAT_CYC)), is 0 on entry to PRESSED and to HELD.
- IDLE:
  - On level rise with en=1: pulse_press <= 1, go to PRESSED.
  - On level rise with en=0: go to WAIT_REL, no pulse.
- PRESSED:
  - hcnt increments each edge.
  - When hcnt == LONG_CYC-1: pulse_long <= 1, go to HELD. pulse_long therefore asserts exactly LONG_CYC edges after pulse_press.
- HELD:
  - hcnt increments each edge.
  - When hcnt == REPEAT_CYC-1: pulse_rep <= 1 and hcnt <= 0. pulse_rep fires every REPEAT_CYC edges, first one REPEAT_CYC after pulse_long.
- WAIT_REL: waits with no pulses.
- Any state, en=0 while level=1: go to WAIT_REL, no pulse that cycle. A hold does not resume when en returns high; a fresh press is required.
- Any state, level=0 (release): go to IDLE on the next edge.
  - The release edge coinciding with hcnt terminal count has priority: no pulse is issued.
- Pulses are registered and high for exactly one cycle. At most one of the three pulses is high in any cycle.
- Reset mid-hold:
  - All outputs drop at once.
  - If the button is still held after rst deasserts, level re-debounces from 0. One pulse_press follows DEBOUNCE_CYC+2 edges later. This is the intended behaviour.
- Counters saturate/clear only as stated; there is no wrap-around beyond the terminal compares.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, en=1 unless stated.
1. Reset: assert rst with btn_in=1 for 5 cycles -> level, pulse_press, pulse_long, pulse_rep all 0 throughout.
2. Clean press:
   - Stimulus: btn_in high before edge 0 for 15 cycles, then low.
   - level rises at edge 5; exactly one pulse_press, in the cycle after edge 6; no pulse_long.
   - level falls 5 edges after the release sample.
3. Bounce:
   - Stimulus: btn_in toggles high 3 cycles / low 1 cycle, repeated 5 times, then stays low.
   - level stays 0 and no pulses occur.
   - The same pattern followed by a solid high gives exactly one pulse_press.
4. Long hold:
   - Stimulus: btn_in held 60 cycles.
   - pulse_press at cycle T, pulse_long at T+20, pulse_rep at T+28, T+36, T+44, T+52.
   - Total pulse_rep count ends consistent with the release time.
5. Enable gating:
   - Stimulus: en=0 while pressing, en=1 at cycle 10 while still held.
   - No pulses while held; after release then re-press, pulse_press appears with normal latency.
6. Reset mid-hold:
   - Stimulus: rst asserted at T+25 of a long hold and released 3 cycles later, button kept high.
   - Outputs go 0 immediately; one pulse_press 6 edges after rst release; pulse_long 20 edges after that.

Source files
------------

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: raw push-button to clean command pulses.
// Path: 2-FF synchronizer -> consistency-count debouncer -> press/hold FSM.
// Emits one press pulse, one long-hold pulse, then periodic auto-repeat pulses.
module btn_pulse_gen #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 100_000_000,
   parameter int REPEAT_CYC   = 20_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic en,
   output logic level,
   output logic pulse_press,
   output logic pulse_long,
   output logic pulse_rep
);

   localparam int DW   = $clog2(DEBOUNCE_CYC);
   localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
   localparam int HW   = $clog2(HMAX);

   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] L_LAST = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      HELD,
      WAIT_REL
   } state_t;

   logic          sync1;
   logic          s;
   logic [DW-1:0] dcnt;

   state_t        state, state_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic          press_n, long_n, rep_n;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= btn_in;
         s     <= sync1;
      end
   end

   // Debouncer: level follows s only after DEBOUNCE_CYC consecutive disagreeing edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b0;
         dcnt  <= '0;
      end else if (s != level) begin
         if (dcnt == D_LAST) begin
            level <= s;
            dcnt  <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end else begin
         dcnt <= '0;
      end
   end

   // Press/hold FSM next-state and pulse decode; release beats enable, enable beats terminal counts.
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      press_n = 1'b0;
      long_n  = 1'b0;
      rep_n   = 1'b0;
      if (!level) begin
         state_n = IDLE;
         hcnt_n  = '0;
      end else if (!en) begin
         state_n = WAIT_REL;
         hcnt_n  = '0;
      end else begin
         case (state)
            // IDLE with level high can only mean a fresh rise
            IDLE: begin
               state_n = PRESSED;
               hcnt_n  = '0;
               press_n = 1'b1;
            end
            PRESSED: begin
               if (hcnt == L_LAST) begin
                  state_n = HELD;
                  hcnt_n  = '0;
                  long_n  = 1'b1;
               end else begin
                  hcnt_n = hcnt + 1'b1;
               end
            end
            HELD: begin
               if (hcnt == R_LAST) begin
                  hcnt_n = '0;
                  rep_n  = 1'b1;
               end else begin
                  hcnt_n = hcnt + 1'b1;
               end
            end
            WAIT_REL: begin
               state_n = WAIT_REL;
            end
            default: begin
               state_n = IDLE;
               hcnt_n  = '0;
            end
         endcase
      end
   end

   // FSM state, hold counter and registered one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         hcnt        <= '0;
         pulse_press <= 1'b0;
         pulse_long  <= 1'b0;
         pulse_rep   <= 1'b0;
      end else begin
         state       <= state_n;
         hcnt        <= hcnt_n;
         pulse_press <= press_n;
         pulse_long  <= long_n;
         pulse_rep   <= rep_n;
      end
   end

endmodule
